// File: rtl/timer_event_capture_if.sv
// timer_event_capture_if: valid/ready drain port carrying {count, timestamp} events.
// Rev 1.0
`default_nettype none

interface timer_event_capture_if #(
  parameter int WIDTH    = 8,
  parameter int TS_WIDTH = 16
);
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_count;
  logic [TS_WIDTH-1:0] out_ts;

  modport master (
    output out_valid,
    output out_count,
    output out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_ts,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/timer_event_capture.sv
// timer_event_capture: timestamps rising edges of done_in into a show-ahead FIFO.
// Rev 1.0
`default_nettype none

module timer_event_capture #(
  parameter int WIDTH    = 8,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     done_in,
  input  logic [WIDTH-1:0]         count_in,
  timer_event_capture_if.master    evt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + TS_WIDTH;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [TS_WIDTH-1:0] ts;
  logic                done_d;

  logic event_det;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign event_det = en & done_in & ~done_d;
  assign full      = (level == FULL_LVL);
  assign pop       = evt.out_valid & evt.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
  assign push      = event_det & (~full | pop);
  assign drop      = event_det & full & ~pop;

  assign evt.out_valid = (level != '0);
  assign evt.out_count = mem[rd_ptr][ENT_W-1:TS_WIDTH];
  assign evt.out_ts    = mem[rd_ptr][TS_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d   <= 1'b0;
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done_d <= done_in;
      if (clear) begin
        ts       <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end else begin
        if (en) begin
          ts <= ts + 1'b1;
        end
        if (push) begin
          mem[wr_ptr] <= {count_in, ts};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_event_capture.sv
// tb_timer_event_capture: directed self-checking bench for timer_event_capture.
// Rev 1.0
`default_nettype none

module tb_timer_event_capture;

  localparam int WIDTH    = 8;
  localparam int TS_WIDTH = 4;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic                clear;
  logic                done_in;
  logic [WIDTH-1:0]    count_in;
  logic [$clog2(DEPTH):0] level;
  logic                overflow;
  logic [7:0]          drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Bench-side timestamp: follows the cycle count the captured values should reflect.
  logic [TS_WIDTH-1:0] m_ts = '0;
  logic [TS_WIDTH-1:0] exp_ts [8];
  logic [TS_WIDTH-1:0] frozen;

  timer_event_capture_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH)) bus ();

  timer_event_capture #(
    .WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (clear),
    .done_in  (done_in),
    .count_in (count_in),
    .evt      (bus.master),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n)     m_ts = '0;
    else if (clear) m_ts = '0;
    else if (en)    m_ts = m_ts + 1'b1;
    #1;
  endtask

  task automatic pulse(input logic [7:0] c, output logic [TS_WIDTH-1:0] t);
    count_in = c;
    done_in  = 1'b1;
    t        = m_ts;
    step();
    done_in  = 1'b0;
    step();
  endtask

  initial begin
    logic [TS_WIDTH-1:0] dummy;
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; done_in = 1'b0; count_in = '0;
    bus.out_ready = 1'b0;
    #3;
    check("rst_valid",    bus.out_valid, 0);
    check("rst_level",    level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop",     drop_cnt, 0);
    check("rst_count",    bus.out_count, 0);
    check("rst_ts",       bus.out_ts, 0);
    step(); step();
    rst_n = 1'b1; en = 1'b1;

    // Single event at ts=5, done_in held high for 10 cycles.
    for (int i = 0; i < 5; i++) step();
    count_in = 8'hFF; done_in = 1'b1;
    step();
    check("t1_valid", bus.out_valid, 1);
    check("t1_count", bus.out_count, 8'hFF);
    check("t1_ts",    bus.out_ts, 5);
    check("t1_level", level, 1);
    for (int i = 0; i < 9; i++) step();
    check("t1_level_hold", level, 1);
    done_in = 1'b0;
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    check("t1_pop_level", level, 0);
    check("t1_pop_valid", bus.out_valid, 0);

    // Fill and overflow: six pulses into a four-deep FIFO.
    for (int i = 0; i < 6; i++) begin
      pulse(8'h10 + 8'(i), exp_ts[i]);
    end
    check("t2_level",    level, 4);
    check("t2_overflow", overflow, 1);
    check("t2_drop",     drop_cnt, 2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_ts",    bus.out_ts, exp_ts[i]);
      check("t2_drain_count", bus.out_count, 8'h10 + 8'(i));
      step();
    end
    bus.out_ready = 1'b0;
    check("t2_empty",       level, 0);
    check("t2_ovf_sticky",  overflow, 1);

    // Full FIFO, event coincides with a pop.
    for (int i = 0; i < 4; i++) begin
      pulse(8'h20 + 8'(i), exp_ts[i]);
    end
    count_in = 8'h2F; done_in = 1'b1; bus.out_ready = 1'b1;
    exp_ts[4] = m_ts;
    step();
    done_in = 1'b0; bus.out_ready = 1'b0;
    check("t3_level", level, 4);
    check("t3_drop",  drop_cnt, 2);
    check("t3_head",  bus.out_count, 8'h21);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t3_drain_count", bus.out_count, (i == 4) ? 8'h2F : 8'h20 + 8'(i));
      check("t3_drain_ts",    bus.out_ts, exp_ts[i]);
      step();
    end
    bus.out_ready = 1'b0;
    check("t3_empty", level, 0);

    // Clear with three entries present and done_in high.
    pulse(8'h30, dummy);
    pulse(8'h31, dummy);
    count_in = 8'h32; done_in = 1'b1;
    step();
    check("t4_level_pre", level, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t4_level",    level, 0);
    check("t4_valid",    bus.out_valid, 0);
    check("t4_overflow", overflow, 0);
    check("t4_drop",     drop_cnt, 0);
    step(); step(); step();
    check("t4_no_event", level, 0);
    done_in = 1'b0; step();
    count_in = 8'h33; done_in = 1'b1; step();
    done_in = 1'b0;
    check("t4_new_ts",    bus.out_ts, 4);
    check("t4_new_count", bus.out_count, 8'h33);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Enable gating: timestamp frozen and edges ignored.
    en = 1'b0;
    frozen = m_ts;
    for (int i = 0; i < 20; i++) begin
      done_in = i[0];
      step();
    end
    check("t5_gated", level, 0);
    done_in = 1'b0; step();
    en = 1'b1; count_in = 8'h50; done_in = 1'b1; step();
    done_in = 1'b0;
    check("t5_frozen_ts", bus.out_ts, frozen);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Timestamp wrap: event sampled at 15, next one after the wrap at 1.
    for (int i = 0; i < 16 && m_ts != 4'hF; i++) step();
    done_in = 1'b1; step();
    done_in = 1'b0; step();
    done_in = 1'b1; step();
    done_in = 1'b0;
    check("t5_wrap_level", level, 2);
    check("t5_wrap_ts15",  bus.out_ts, 15);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    check("t5_wrap_ts1",   bus.out_ts, 1);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

    // Reset mid-operation with two entries and three drops.
    for (int i = 0; i < 7; i++) pulse(8'h60 + 8'(i), dummy);
    bus.out_ready = 1'b1; step(); step(); bus.out_ready = 1'b0;
    check("t6_level_pre", level, 2);
    check("t6_drop_pre",  drop_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid",    bus.out_valid, 0);
    check("t6_level",    level, 0);
    check("t6_overflow", overflow, 0);
    check("t6_drop",     drop_cnt, 0);
    check("t6_count",    bus.out_count, 0);
    check("t6_ts",       bus.out_ts, 0);
    step(); step();
    rst_n = 1'b1; en = 1'b1; done_in = 1'b0;
    step(); step(); step();
    count_in = 8'h77; done_in = 1'b1; step();
    done_in = 1'b0;
    check("t6_post_ts",    bus.out_ts, 3);
    check("t6_post_count", bus.out_count, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
